// File: rtl/whac_pkg.sv
// Shared types for the whack-a-mole blocks: round states, result codes
// and the default hole count.
package whac_pkg;

    localparam int N_MOLES_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        MISS    = 2'd1,
        PARTIAL = 2'd2,
        FULL    = 2'd3
    } result_e;

endpackage

// File: rtl/mole_round_controller_if.sv
// Round controller bus: start/spawn/press inputs and the mask, status
// and result pulses. master = front-end side, slave = controller side.
interface mole_round_controller_if
    import whac_pkg::*;
#(
    parameter int N_MOLES = N_MOLES_DEF
);
    logic               start;
    logic [N_MOLES-1:0] spawn_mask;
    logic [N_MOLES-1:0] btn_pulse;
    logic [N_MOLES-1:0] moles_active;
    logic               round_active;
    logic               round_done;
    logic               miss;
    logic               non_full_clear_hit;
    logic               full_clear_hit;

    modport master (
        output start, spawn_mask, btn_pulse,
        input  moles_active, round_active, round_done,
        input  miss, non_full_clear_hit, full_clear_hit
    );

    modport slave (
        input  start, spawn_mask, btn_pulse,
        output moles_active, round_active, round_done,
        output miss, non_full_clear_hit, full_clear_hit
    );
endinterface

// File: rtl/mole_round_controller_round_timer.sv
// Round time-limit down-counter. Ports: clk, rst, load_i (reload to
// ROUND_CYCLES-1), dec_i (count down, holds at 0), expired_o (count = 0).
module round_timer #(
    parameter int ROUND_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic expired_o
);
    localparam int W = $clog2(ROUND_CYCLES);
    localparam logic [W-1:0] LOAD_VAL = W'(ROUND_CYCLES - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = LOAD_VAL;
        end else if (dec_i && count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);
endmodule

// File: rtl/mole_round_controller.sv
// Round sequencer: loads the mole set, judges presses, enforces the time
// limit. Ports: clk, rst, bus (slave: start/spawn/press in, mask/status/pulses out).
module mole_round_controller
    import whac_pkg::*;
#(
    parameter int N_MOLES      = N_MOLES_DEF,
    parameter int ROUND_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    mole_round_controller_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'(IDLE);
    localparam logic [1:0] S_ACTIVE = 2'(ACTIVE);
    localparam logic [1:0] S_DONE   = 2'(DONE);

    logic [1:0]         state_q, state_d;
    logic [N_MOLES-1:0] mask_q, mask_d;
    logic               miss_q, miss_d;
    logic               part_q, part_d;
    logic               full_q, full_d;

    logic [N_MOLES-1:0] hits, wrong, rest;
    logic               t_load, t_dec, t_expired;
    result_e            res;

    round_timer #(
        .ROUND_CYCLES(ROUND_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (t_load),
        .dec_i     (t_dec),
        .expired_o (t_expired)
    );

    assign hits  = bus.btn_pulse & mask_q;
    assign wrong = bus.btn_pulse & ~mask_q;
    assign rest  = mask_q & ~hits;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        res     = NONE;
        t_load  = 1'b0;
        t_dec   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start && |bus.spawn_mask) begin
                    mask_d  = bus.spawn_mask;
                    t_load  = 1'b1;
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (|wrong) begin
                    // A wrong press on the last cycle still ends the round,
                    // folding the timeout into this single miss.
                    res = MISS;
                    if (t_expired) begin
                        mask_d  = '0;
                        state_d = S_DONE;
                    end
                end else if (|hits && rest == '0) begin
                    res     = FULL;
                    mask_d  = '0;
                    state_d = S_DONE;
                end else if (|hits) begin
                    res    = PARTIAL;
                    mask_d = rest;
                end else if (t_expired) begin
                    res     = MISS;
                    mask_d  = '0;
                    state_d = S_DONE;
                end else begin
                    t_dec = 1'b1;
                end
            end
            S_DONE: begin
                mask_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                mask_d  = '0;
                state_d = S_IDLE;
            end
        endcase
        miss_d = (res == MISS);
        part_d = (res == PARTIAL);
        full_d = (res == FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            miss_q  <= 1'b0;
            part_q  <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            miss_q  <= miss_d;
            part_q  <= part_d;
            full_q  <= full_d;
        end
    end

    assign bus.moles_active       = mask_q;
    assign bus.round_active       = (state_q == S_ACTIVE);
    assign bus.round_done         = (state_q == S_DONE);
    assign bus.miss               = miss_q;
    assign bus.non_full_clear_hit = part_q;
    assign bus.full_clear_hit     = full_q;
endmodule

// File: doc/mole_round_controller.md
# mole_round_controller

Round sequencer that sits between the mole spawner/button front-end and `combo_counter`. It loads a set of active moles, judges each debounced button press against that set, and enforces a round time limit. It emits at most one of `miss`, `non_full_clear_hit` or `full_clear_hit` per cycle as a registered one-cycle pulse, so the combo counter never sees overlapping or stretched events.

## Interface

Parameters:
- `N_MOLES`, default 8: number of holes; width of the mask and button vectors.
- `ROUND_CYCLES`, default 50_000_000: clock cycles a round stays in ACTIVE before timeout. Must be ≥ 2.

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request to begin a round. Sampled only in IDLE.
- `spawn_mask`  in  N_MOLES  moles to raise, captured with `start`.
- `btn_pulse`  in  N_MOLES  debounced presses, one-cycle pulses per hole.
- `moles_active`  out  N_MOLES  moles still up. Reset value 0.
- `round_active`  out  1  high while in ACTIVE. Reset value 0.
- `round_done`  out  1  one-cycle end-of-round strobe. Reset value 0.
- `miss`  out  1  one-cycle pulse to `combo_counter`. Reset value 0.
- `non_full_clear_hit`  out  1  one-cycle pulse. Reset value 0.
- `full_clear_hit`  out  1  one-cycle pulse. Reset value 0.

## Operation

- The states are IDLE, ACTIVE and DONE. Reset forces IDLE and clears every output and the timer.
- **IDLE**
  - When `start` = 1 and `spawn_mask` ≠ 0, load `moles_active` = `spawn_mask` and timer = ROUND_CYCLES−1, then go to ACTIVE.
  - When `start` = 1 and `spawn_mask` = 0, ignore the request and stay in IDLE.
  - `btn_pulse` is ignored; IDLE presses produce no pulse.
- **ACTIVE** evaluates each cycle, in this priority order:
  - Let `hits = btn_pulse & moles_active` and `wrong = btn_pulse & ~moles_active`.
  - If `wrong` ≠ 0: register `miss`. The mask is unchanged, even if `hits` ≠ 0 in the same cycle.
  - Else if `hits` ≠ 0 and `moles_active & ~hits` = 0: register `full_clear_hit`, clear the mask, go to DONE.
  - Else if `hits` ≠ 0: register `non_full_clear_hit` and set `moles_active &= ~hits`. Multiple hits in one cycle give a single pulse.
  - Else if timer = 0: register `miss`, clear the mask, go to DONE.
  - Else: decrement the timer.
  - A clearing hit on the timer = 0 cycle wins over the timeout. A wrong press on the timer = 0 cycle gives `miss` and ends the round (one pulse only).
  - `start` is ignored in ACTIVE.
- **DONE** lasts one cycle:
  - `round_done` = 1 and the mask is 0.
  - Presses are ignored.
  - The next state is always IDLE; a `start` in DONE is dropped.
- The three result pulses are mutually exclusive, and none is asserted for two consecutive cycles from a single one-cycle press.

## Timing

- All outputs are registered. Latency is 1 cycle: a press sampled at edge k gives its pulse and mask update visible after edge k.
- Round start: `start` at edge k gives `round_active` = 1 and a loaded `moles_active` after edge k.
- Timeout: with no presses, `miss` and `round_done` are visible after edge k+ROUND_CYCLES, both for exactly one cycle. `round_active` falls at the same edge.
- `round_done` coincides with the final `full_clear_hit` or timeout `miss`. The earliest next `start` is sampled the cycle after `round_done`.
- Reset mid-round takes effect at the next edge: outputs go to 0 with no result pulse emitted. While `rst` = 1, `start` has no effect.
- The timer width is `$clog2(ROUND_CYCLES)`. It must not wrap: it holds at 0 only until the exit from ACTIVE.

## Structure

- A shared package `whac_pkg` holds:
  - the state enum (IDLE, ACTIVE, DONE);
  - the default `N_MOLES`;
  - a result-code enum (NONE, MISS, PARTIAL, FULL), reused by the score and display blocks.
- Sub-module `round_timer`: a load/decrement down-counter with an `expired` flag (timer = 0), parameterised by ROUND_CYCLES.
- The judging logic and FSM stay in the top module. Each result pulse comes from its own flop.

## Test plan

Use N_MOLES = 4 and ROUND_CYCLES = 16.

1. `start` with `spawn_mask` = 4'b0101, then `btn_pulse` = 0001 at cycle 3 → `non_full_clear_hit` for 1 cycle and `moles_active` = 0100. Then `btn_pulse` = 0100 → `full_clear_hit` and `round_done` for 1 cycle, `moles_active` = 0000, back in IDLE.
2. Mask 0101, `btn_pulse` = 0010 → `miss` for 1 cycle, mask stays 0101. Then `btn_pulse` = 0011 → `miss` only, mask stays 0101.
3. Mask 0101, `btn_pulse` = 0101 in one cycle → a single `full_clear_hit` and no `non_full_clear_hit`.
4. Mask 0011 with no presses → `miss` and `round_done` exactly 16 cycles after the start edge, `round_active` = 0. A clearing press on the timer = 0 cycle instead → `full_clear_hit`, no `miss`.
5. `rst` held high for 3 cycles mid-ACTIVE with mask 0110 → all outputs 0 and no pulses. `start` while `rst` = 1 is ignored. `start` with mask 0000 after release stays in IDLE.
6. A press in IDLE, and `start` during ACTIVE or DONE → no pulses, and the mask is not reloaded.
